// File: rtl/voting_machine_param.sv
// Parametrised voting machine: hold-to-vote button bank with saturating tallies,
// a registered result display and registered winner/tie tracking.
module voting_machine_param #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [NUM_CAND-1:0]         button,
    output logic [CNT_W-1:0]            led,
    output logic                        vote_valid,
    output logic [$clog2(NUM_CAND)-1:0] vote_idx,
    output logic                        vote_reject,
    output logic [$clog2(NUM_CAND)-1:0] winner_idx,
    output logic                        winner_valid,
    output logic                        tie,
    output logic                        sat
);
    localparam int IW = $clog2(NUM_CAND);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, ARM, REJ, WREL} state_t;

    state_t              state;
    logic [HW-1:0]       hold_cnt;
    logic [NUM_CAND-1:0] pat;
    logic                mode_d;
    logic [CNT_W-1:0]    tally [NUM_CAND];

    logic                any_btn;
    logic                multi;
    logic                single;
    logic                cast;
    logic [IW-1:0]       btn_idx;
    logic [CNT_W-1:0]    max_v;
    logic [IW-1:0]       max_i;
    logic                shared;

    function automatic logic [IW-1:0] low_idx(input logic [NUM_CAND-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A vote lands on the edge that completes HOLD_CYC consecutive samples of one lone button.
    always_comb begin
        any_btn = |button;
        multi   = |(button & (button - NUM_CAND'(1)));
        single  = any_btn && !multi;
        btn_idx = low_idx(button);
        cast    = 1'b0;
        if (!mode) begin
            if (state == IDLE)
                cast = (HOLD_CYC == 1) && single && !mode_d;
            else if (state == ARM)
                cast = (button == pat) && (hold_cnt == HOLD_LAST);
        end
    end

    always_comb begin
        max_v  = '0;
        max_i  = '0;
        shared = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (tally[i] > max_v) begin
                max_v = tally[i];
                max_i = IW'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (IW'(i) != max_i && tally[i] == max_v) shared = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            pat         <= '0;
            mode_d      <= 1'b0;
            vote_valid  <= 1'b0;
            vote_idx    <= '0;
            vote_reject <= 1'b0;
        end else begin
            mode_d      <= mode;
            vote_valid  <= cast;
            vote_reject <= 1'b0;
            if (cast) vote_idx <= btn_idx;
            if (mode) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hold_cnt <= '0;
                        // Coming back from result mode with a button still down needs a release first.
                        if (mode_d && any_btn) begin
                            state <= WREL;
                        end else if (multi) begin
                            state       <= REJ;
                            vote_reject <= 1'b1;
                        end else if (single) begin
                            pat      <= button;
                            hold_cnt <= HW'(1);
                            state    <= cast ? WREL : ARM;
                        end
                    end
                    ARM: begin
                        if (cast) begin
                            state    <= WREL;
                            hold_cnt <= '0;
                        end else if (button == pat) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end else begin
                            hold_cnt <= '0;
                            if (multi) begin
                                state       <= REJ;
                                vote_reject <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    REJ:  state <= WREL;
                    WREL: if (!any_btn) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            sat <= 1'b0;
        end else if (cast) begin
            tally[btn_idx] <= sat_inc(tally[btn_idx]);
            if (tally[btn_idx] == '1) sat <= 1'b1;
        end
    end

    // Display and winner registers trail the tallies by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led          <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
        end else begin
            led          <= (mode && any_btn) ? tally[btn_idx] : '0;
            winner_idx   <= max_i;
            winner_valid <= (max_v != '0);
            tie          <= shared && (max_v != '0);
        end
    end

endmodule

// File: tb/tb_voting_machine_param.sv
// Randomised and directed bench for voting_machine_param with a run-length reference
// model feeding an event scoreboard and per-cycle output expectations.
module tb_voting_machine_param;
    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int HOLD = 10;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [NC-1:0] button;
    logic [CW-1:0] led;
    logic          vote_valid;
    logic [1:0]    vote_idx;
    logic          vote_reject;
    logic [1:0]    winner_idx;
    logic          winner_valid;
    logic          tie;
    logic          sat;

    voting_machine_param #(.NUM_CAND(NC), .CNT_W(CW), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst), .mode(mode), .button(button), .led(led),
        .vote_valid(vote_valid), .vote_idx(vote_idx), .vote_reject(vote_reject),
        .winner_idx(winner_idx), .winner_valid(winner_valid), .tie(tie), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rej;
        int idx;
        int cyc;
    } ev_t;

    ev_t evq[$];
    int  checks = 0;
    int  errors = 0;
    int  nvote  = 0;
    int  nrej   = 0;

    // Reference model state
    int       cyc = 0;
    int       tal[NC];
    int       run_len;
    logic [NC-1:0] run_pat;
    bit       need_rel, skip, prev_mode;
    int       exp_led, exp_widx, exp_wv, exp_tie, exp_sat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic m, input logic [NC-1:0] b, input int n);
        mode   = m;
        button = b;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(posedge clk) begin
        int maxv, cnt, n, idx;
        ev_t e;
        cyc++;
        if (!rst) begin
            foreach (tal[i]) tal[i] = 0;
            run_len = 0; run_pat = '0; need_rel = 0; skip = 0; prev_mode = 0;
            exp_led = 0; exp_widx = 0; exp_wv = 0; exp_tie = 0; exp_sat = 0;
            evq.delete();
        end else begin
            exp_led = 0;
            if (mode) for (int i = NC - 1; i >= 0; i--) if (button[i]) exp_led = tal[i];
            maxv = 0; exp_widx = 0; cnt = 0;
            for (int i = 0; i < NC; i++) if (tal[i] > maxv) begin maxv = tal[i]; exp_widx = i; end
            for (int i = 0; i < NC; i++) if (tal[i] == maxv) cnt++;
            exp_wv  = (maxv > 0);
            exp_tie = (maxv > 0) && (cnt >= 2);

            n = $countones(button);
            if (mode) begin
                run_len = 0; need_rel = 0; skip = 0;
            end else if (skip) begin
                skip = 0; need_rel = 1;
            end else if (need_rel) begin
                if (n == 0) need_rel = 0;
            end else if (prev_mode && n != 0) begin
                need_rel = 1;
            end else if (n > 1) begin
                e.rej = 1; e.idx = 0; e.cyc = cyc; evq.push_back(e);
                skip = 1; run_len = 0;
            end else if (n == 0) begin
                run_len = 0;
            end else if (run_len > 0 && button != run_pat) begin
                run_len = 0;
            end else begin
                if (run_len == 0) run_pat = button;
                run_len++;
                if (run_len == HOLD) begin
                    idx = 0;
                    for (int i = 0; i < NC; i++) if (button[i]) idx = i;
                    if (tal[idx] == MAXV) exp_sat = 1;
                    else tal[idx]++;
                    e.rej = 0; e.idx = idx; e.cyc = cyc; evq.push_back(e);
                    run_len = 0; need_rel = 1;
                end
            end
            prev_mode = mode;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            chk("reset_outs", 32'({led, vote_valid, vote_idx, vote_reject, winner_idx,
                                   winner_valid, tie, sat}), 32'd0);
        end else begin
            chk("led", 32'(led), 32'(exp_led));
            chk("winner_idx", 32'(winner_idx), 32'(exp_widx));
            chk("winner_valid", 32'(winner_valid), 32'(exp_wv));
            chk("tie", 32'(tie), 32'(exp_tie));
            chk("sat", 32'(sat), 32'(exp_sat));
            if (vote_valid) nvote++;
            if (vote_reject) nrej++;
            if (vote_valid || vote_reject) begin
                if (evq.size() == 0) begin
                    chk("unexpected_event", 32'({vote_reject, vote_valid}), 32'd0);
                end else begin
                    e = evq.pop_front();
                    chk("event_kind", 32'({vote_reject, vote_valid}), e.rej ? 32'd2 : 32'd1);
                    if (!e.rej) chk("vote_idx", 32'(vote_idx), 32'(e.idx));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                chk("missing_event", 32'(e.cyc), 32'(-1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base_v, base_r, r, len;
        logic [NC-1:0] b;
        rst = 1'b0; mode = 1'b0; button = '0;
        repeat (10) begin @(posedge clk); #2; end
        rst = 1'b1;
        drive(0, 4'b0000, 2);
        for (int i = 0; i < NC; i++) begin
            drive(1, NC'(1 << i), 3);
            chk("t1_led_zero", 32'(led), 32'd0);
        end
        drive(0, 4'b0000, 2);

        base_v = nvote;
        drive(0, 4'b0001, 200);
        drive(0, 4'b0000, 3);
        chk("t2_one_vote", 32'(nvote - base_v), 32'd1);
        chk("t2_vote_idx", 32'(vote_idx), 32'd0);
        drive(1, 4'b0001, 2);
        chk("t2_led", 32'(led), 32'd1);

        base_v = nvote; base_r = nrej;
        drive(0, 4'b0010, 5);
        drive(0, 4'b0000, 2);
        drive(0, 4'b0110, 200);
        drive(0, 4'b0000, 3);
        chk("t3_no_vote", 32'(nvote - base_v), 32'd0);
        chk("t3_one_reject", 32'(nrej - base_r), 32'd1);

        base_v = nvote;
        drive(1, 4'b0010, 200);
        chk("t4_led_tally1", 32'(led), 32'd0);
        drive(0, 4'b0010, 20);
        chk("t4_held_no_vote", 32'(nvote - base_v), 32'd0);
        drive(0, 4'b0000, 2);
        drive(0, 4'b0010, 12);
        drive(0, 4'b0000, 2);
        chk("t4_repress_vote", 32'(nvote - base_v), 32'd1);

        drive(0, 4'b0100, 5);
        rst = 1'b0;
        drive(0, 4'b0000, 3);
        rst = 1'b1;
        drive(0, 4'b0000, 2);
        chk("t5_winner_cleared", 32'({winner_valid, tie}), 32'd0);
        drive(0, 4'b0001, 12);
        drive(0, 4'b0000, 3);
        drive(0, 4'b0010, 12);
        drive(0, 4'b0000, 3);
        chk("t5_tie", 32'({tie, winner_valid, winner_idx}), 32'b1_1_00);

        for (int s = 0; s < 300; s++) begin
            r = int'($urandom % 4);
            case (r)
                0:       b = '0;
                3:       b = NC'($urandom % 16);
                default: b = NC'(1 << ($urandom % 4));
            endcase
            len = int'($urandom_range(1, 14));
            drive(($urandom % 5) == 0, b, len);
        end
        drive(0, 4'b0000, 3);

        for (int v = 0; v < 260; v++) begin
            drive(0, 4'b1000, 11);
            drive(0, 4'b0000, 2);
        end
        chk("t6_sat", 32'(sat), 32'd1);
        chk("t6_winner3", 32'(winner_idx), 32'd3);
        drive(1, 4'b1000, 2);
        chk("t6_led_max", 32'(led), 32'(MAXV));
        drive(0, 4'b0000, 5);
        chk("queue_drained", 32'(evq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
